// File: rtl/csr_trap_seq.sv
// Purpose: shares the CSR file port between core CSR accesses, trap entry and mret; runs the trap/mret CSR sequences and issues a fetch redirect.
// Latency: core write ack +1, core read ack +2, mret redirect +4, trap redirect +6 cycles after acceptance.
// Backpressure: requests are accepted only in IDLE (trap > mret > core); losers hold their request. Define CSR_TRAP_VECTORED_EN for vectored interrupt targets.
module csr_trap_seq #(
    parameter logic [31:0] MSTATUS_ADDR = 32'h300,
    parameter logic [31:0] MEPC_ADDR    = 32'h341,
    parameter logic [31:0] MCAUSE_ADDR  = 32'h342,
    parameter logic [31:0] MTVEC_ADDR   = 32'h305
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_ack_o,
    output logic [31:0] core_rdata_o,
    input  logic        trap_req_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    output logic        trap_ack_o,
    input  logic        mret_req_i,
    output logic        mret_ack_o,
    output logic        busy_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] csr_addr_o,
    output logic        csr_we_o,
    output logic        csr_re_o,
    output logic [31:0] csr_wdata_o,
    output logic        csr_except_o,
    input  logic [31:0] csr_rdata_i
);

    typedef enum logic [3:0] {
        IDLE, CORE_WR, CORE_RD, CORE_RDD,
        T_EPC, T_CAUSE, T_STRD, T_STWR, T_VRD, T_VEC,
        M_EPCRD, M_STRD, M_STWR, M_RDIR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] op_addr_q, op_addr_d;
    logic [31:0] op_wdata_q, op_wdata_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d, re_q, re_d, except_q, except_d, busy_q, busy_d;
    logic        core_ack_q, core_ack_d, redir_q, redir_d;
    logic        idle, core_acc;
    logic [31:0] vec_base, trap_target;

    // mstatus after trap entry: MPIE <= MIE, MIE <= 0, MPP <= M
    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mstatus after mret: MIE <= MPIE, MPIE <= 1, MPP <= M
    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Acceptance is suppressed while reset is asserted so no requester sees a stray ack.
    assign idle       = (state_q == IDLE) && !rst_i;
    assign trap_ack_o = idle && trap_req_i;
    assign mret_ack_o = idle && mret_req_i && !trap_req_i;
    assign core_acc   = idle && core_req_i && !trap_req_i && !mret_req_i;

    // mtvec arrives from the CSR file in T_VEC; the mode bits only matter in vectored builds.
    assign vec_base = csr_rdata_i & 32'hFFFF_FFFC;
`ifdef CSR_TRAP_VECTORED_EN
    assign trap_target = (csr_rdata_i[1:0] == 2'b01 && cause_q[31]) ?
                         vec_base + {cause_q[29:0], 2'b00} : vec_base;
`else
    assign trap_target = vec_base;
`endif

    // Next-state and operand latching: arbitration only in IDLE, fixed walk otherwise.
    always_comb begin
        state_d    = state_q;
        op_addr_d  = op_addr_q;
        op_wdata_d = op_wdata_q;
        cause_d    = cause_q;
        pc_d       = pc_q;
        mepc_d     = mepc_q;
        case (state_q)
            IDLE: begin
                if (trap_ack_o) begin
                    state_d = T_EPC;
                    cause_d = trap_cause_i;
                    pc_d    = trap_pc_i;
                end else if (mret_ack_o) begin
                    state_d = M_EPCRD;
                end else if (core_acc) begin
                    state_d    = core_we_i ? CORE_WR : CORE_RD;
                    op_addr_d  = core_addr_i;
                    op_wdata_d = core_wdata_i;
                end
            end
            CORE_WR:  state_d = IDLE;
            CORE_RD:  state_d = CORE_RDD;
            CORE_RDD: state_d = IDLE;
            T_EPC:    state_d = T_CAUSE;
            T_CAUSE:  state_d = T_STRD;
            T_STRD:   state_d = T_STWR;
            T_STWR:   state_d = T_VRD;
            T_VRD:    state_d = T_VEC;
            T_VEC:    state_d = IDLE;
            M_EPCRD:  state_d = M_STRD;
            M_STRD: begin
                state_d = M_STWR;
                mepc_d  = csr_rdata_i;
            end
            M_STWR:   state_d = M_RDIR;
            M_RDIR:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they leave a flop.
    always_comb begin
        addr_d     = 32'h0;
        we_d       = 1'b0;
        re_d       = 1'b0;
        except_d   = 1'b0;
        core_ack_d = 1'b0;
        redir_d    = 1'b0;
        busy_d     = (state_d != IDLE);
        case (state_d)
            CORE_WR:  begin addr_d = op_addr_d; we_d = 1'b1; core_ack_d = 1'b1; end
            CORE_RD:  begin addr_d = op_addr_d; re_d = 1'b1; end
            CORE_RDD: core_ack_d = 1'b1;
            T_EPC:    begin addr_d = MEPC_ADDR;    we_d = 1'b1; except_d = 1'b1; end
            T_CAUSE:  begin addr_d = MCAUSE_ADDR;  we_d = 1'b1; except_d = 1'b1; end
            T_STRD:   begin addr_d = MSTATUS_ADDR; re_d = 1'b1; except_d = 1'b1; end
            T_STWR:   begin addr_d = MSTATUS_ADDR; we_d = 1'b1; except_d = 1'b1; end
            T_VRD:    begin addr_d = MTVEC_ADDR;   re_d = 1'b1; except_d = 1'b1; end
            T_VEC:    begin redir_d = 1'b1; except_d = 1'b1; end
            M_EPCRD:  begin addr_d = MEPC_ADDR;    re_d = 1'b1; except_d = 1'b1; end
            M_STRD:   begin addr_d = MSTATUS_ADDR; re_d = 1'b1; except_d = 1'b1; end
            M_STWR:   begin addr_d = MSTATUS_ADDR; we_d = 1'b1; except_d = 1'b1; end
            M_RDIR:   begin redir_d = 1'b1; except_d = 1'b1; end
            default:  ;
        endcase
    end

    // State, latched operands and registered control outputs; reset clears everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_addr_q  <= 32'h0;
            op_wdata_q <= 32'h0;
            cause_q    <= 32'h0;
            pc_q       <= 32'h0;
            mepc_q     <= 32'h0;
            addr_q     <= 32'h0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            except_q   <= 1'b0;
            busy_q     <= 1'b0;
            core_ack_q <= 1'b0;
            redir_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_addr_q  <= op_addr_d;
            op_wdata_q <= op_wdata_d;
            cause_q    <= cause_d;
            pc_q       <= pc_d;
            mepc_q     <= mepc_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            re_q       <= re_d;
            except_q   <= except_d;
            busy_q     <= busy_d;
            core_ack_q <= core_ack_d;
            redir_q    <= redir_d;
        end
    end

    // Data paths that depend on the CSR file's read data must follow it in the same cycle.
    always_comb begin
        csr_wdata_o   = 32'h0;
        redirect_pc_o = 32'h0;
        core_rdata_o  = 32'h0;
        case (state_q)
            CORE_WR:  csr_wdata_o   = op_wdata_q;
            CORE_RDD: core_rdata_o  = csr_rdata_i;
            T_EPC:    csr_wdata_o   = pc_q & 32'hFFFF_FFFC;
            T_CAUSE:  csr_wdata_o   = cause_q;
            T_STWR:   csr_wdata_o   = trap_mstatus(csr_rdata_i);
            T_VEC:    redirect_pc_o = trap_target;
            M_STWR:   csr_wdata_o   = mret_mstatus(csr_rdata_i);
            M_RDIR:   redirect_pc_o = mepc_q & 32'hFFFF_FFFC;
            default:  ;
        endcase
    end

    assign csr_addr_o       = addr_q;
    assign csr_we_o         = we_q;
    assign csr_re_o         = re_q;
    assign csr_except_o     = except_q;
    assign busy_o           = busy_q;
    assign core_ack_o       = core_ack_q;
    assign redirect_valid_o = redir_q;

endmodule

// File: doc/csr_trap_seq.md
# csr_trap_seq

Trap and return sequencer for the machine-mode CSR register file (`scr1`). It shares the CSR file's single access port between three requesters: the core's CSR-instruction path, trap entry, and `mret`. For trap entry and `mret` it runs the fixed write and read-modify-write sequences over `mepc`, `mcause`, `mstatus` and `mtvec`, then issues a one-cycle PC redirect to fetch.

## Interface
- `MSTATUS_ADDR`, default 32'h300: CSR address of mstatus.
- `MEPC_ADDR`, default 32'h341: CSR address of mepc.
- `MCAUSE_ADDR`, default 32'h342: CSR address of mcause.
- `MTVEC_ADDR`, default 32'h305: CSR address of mtvec.
- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `core_req_i` in 1: core CSR access request; held until `core_ack_o`.
- `core_we_i` in 1: 1 = write, 0 = read.
- `core_addr_i` in 32: CSR address.
- `core_wdata_i` in 32: write data.
- `core_ack_o` out 1: one-cycle completion pulse.
- `core_rdata_o` out 32: read data, valid while `core_ack_o` is high.
- `trap_req_i` in 1: trap request; held until `trap_ack_o`.
- `trap_cause_i` in 32: mcause value; bit 31 = interrupt.
- `trap_pc_i` in 32: faulting PC.
- `trap_ack_o` out 1: trap accepted.
- `mret_req_i` in 1: mret request; held until `mret_ack_o`.
- `mret_ack_o` out 1: mret accepted.
- `busy_o` out 1: sequencer not in IDLE.
- `redirect_valid_o` out 1: one-cycle redirect pulse.
- `redirect_pc_o` out 32: redirect target.
- `csr_addr_o` out 32: address to the CSR file.
- `csr_we_o` out 1: write enable to the CSR file.
- `csr_re_o` out 1: read enable to the CSR file.
- `csr_wdata_o` out 32: write data to the CSR file.
- `csr_except_o` out 1: drives the CSR file's exception-mode input.
- `csr_rdata_i` in 32: CSR file registered read data; valid the cycle after `csr_re_o`.

## Operation
- FSM states:
  - IDLE, CORE_WR, CORE_RD, CORE_RDD
  - T_EPC, T_CAUSE, T_STRD, T_STWR, T_VRD, T_VEC
  - M_EPCRD, M_STRD, M_STWR, M_RDIR
- Arbitration happens only in IDLE, priority trap > mret > core.
  - Acks are combinational: `trap_ack_o = IDLE & trap_req_i`; `mret_ack_o = IDLE & mret_req_i & ~trap_req_i`.
  - Losing requesters are not acked and must hold their request.
- On acceptance, the request operands (address, data, cause, pc) are latched.
- Core write: CORE_WR drives `csr_we_o=1` and `core_ack_o=1`, then returns to IDLE.
- Core read:
  - CORE_RD drives `csr_re_o`.
  - CORE_RDD drives `core_ack_o=1` with `core_rdata_o = csr_rdata_i`.
- Trap entry:
  - T_EPC writes mepc = `{pc[31:2],2'b00}`.
  - T_CAUSE writes mcause = cause.
  - T_STRD reads mstatus.
  - T_STWR writes mstatus' from the read value: MPIE(bit 7) = MIE(bit 3), MIE = 0, MPP(12:11) = 2'b11, all other bits unchanged.
  - T_VRD reads mtvec.
  - T_VEC asserts `redirect_valid_o` with `redirect_pc_o = {mtvec[31:2],2'b00}`, subject to the vectored-mode rule in Configuration.
- mret:
  - M_EPCRD reads mepc.
  - M_STRD latches mepc from `csr_rdata_i` and reads mstatus.
  - M_STWR writes MIE = MPIE, MPIE = 1, MPP = 2'b11, other bits unchanged.
  - M_RDIR asserts the redirect with `redirect_pc_o = {mepc[31:2],2'b00}`.
- `csr_except_o` is 1 in every T_* and M_* state and 0 elsewhere.
- `busy_o` is 1 in every state except IDLE.
- In states that do not read or write, `csr_we_o` and `csr_re_o` are 0.
- Arithmetic is 32-bit, with wrap-around on overflow and no saturation.

## Timing
- All outputs are 0 during and after reset (`csr_addr_o` = 0; FSM in IDLE).
- Request sampled at edge k in IDLE:
  - Core write: ack in cycle k+1.
  - Core read: ack in cycle k+2.
  - Trap: redirect in cycle k+6.
  - mret: redirect in cycle k+4.
- Only one CSR file operation per cycle; `csr_we_o` and `csr_re_o` are never high together.
- Simultaneous trap, mret and core requests: trap is acked; mret and core wait until IDLE, and mret is then served before core.
- A request that arrives while busy is not acked and waits for IDLE.
- The earliest re-acceptance is the cycle immediately after the last state of a sequence.
- `rst_i` mid-sequence:
  - Returns to IDLE at the next edge.
  - No redirect and no ack are issued.
  - A partially written trap state is discarded, which is consistent because the CSR file also clears on reset.
- `redirect_valid_o` is exactly one cycle wide and is never asserted in the same cycle as `core_ack_o`.

## Configuration
- `CSR_TRAP_VECTORED_EN` defined:
  - If mtvec[1:0] == 2'b01 and cause[31] == 1, then `redirect_pc_o = {mtvec[31:2],2'b00} + (cause[29:0] << 2)`.
  - Otherwise direct mode applies.
- Undefined: always direct mode; mtvec[1:0] is ignored.

## Test plan
- Core write 0x305 ← 0x0000_1000, then core read 0x305:
  - Write ack 1 cycle after the request.
  - Read ack 2 cycles after the request with rdata 0x0000_1000.
- mstatus = 0x0000_0008, mtvec = 0x1000; trap cause 0x2, pc 0x0000_0456:
  - mepc = 0x454, mcause = 2, mstatus = 0x0000_1880.
  - Redirect 0x1000 at k+6.
  - `csr_except_o` high during cycles k+1 to k+6.
- From the post-trap state, mret:
  - mstatus = 0x0000_1888.
  - Redirect 0x454 at k+4.
- Trap, mret and core read all requested at the same edge:
  - `trap_ack_o` only.
  - mret acked 7 cycles later, core acked after mret completes.
- `rst_i` pulsed at cycle k+3 of a trap:
  - FSM returns to IDLE and all outputs are 0.
  - No redirect is issued and `busy_o` = 0.
- `CSR_TRAP_VECTORED_EN` defined, mtvec = 0x1001, cause 0x8000_0007:
  - Redirect 0x101C.
  - Without the macro: redirect 0x1000.
